// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional build macro MULDIV_DIV0_FAST_EN: divide by zero completes without entering RUN.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | 32 iteration steps, then result write-back
    // FIN   | hi/lo valid, done pulse, may accept the next start
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic        div_q, neg_q, neg_rem_q, y_zero_q;
    logic [31:0] x_q, acc_hi, acc_lo, mag;

    logic        accept, fast_div0, is_signed;
    logic [31:0] x_mag, y_mag;
    logic [32:0] sum, trial, diff;
    logic [31:0] step_hi, step_lo;
    logic [63:0] prod, prod_c;
    logic [31:0] quo, rem, res_hi, res_lo;

    assign accept    = start && (state != RUN);
    assign is_signed = ~op[0];
    assign x_mag     = (is_signed && x[31]) ? -x : x;
    assign y_mag     = (is_signed && y[31]) ? -y : y;

`ifdef MULDIV_DIV0_FAST_EN
    assign fast_div0 = op[1] && (y == 32'd0);
`else
    assign fast_div0 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = fast_div0 ? FIN : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == 6'd32) state_nxt = FIN;
            end
            FIN: begin
                done = 1'b1;
                if (start) state_nxt = fast_div0 ? FIN : RUN;
                else       state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration: multiply adds the multiplicand on lsb and shifts the 64-bit pair right;
    // divide shifts the dividend msb into the remainder and keeps the difference if no borrow.
    always_comb begin
        sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag} : 33'd0);
        trial = {acc_hi, acc_lo[31]};
        diff  = trial - {1'b0, mag};
        if (div_q) begin
            if (!diff[32]) begin
                step_hi = diff[31:0];
                step_lo = {acc_lo[30:0], 1'b1};
            end else begin
                step_hi = trial[31:0];
                step_lo = {acc_lo[30:0], 1'b0};
            end
        end else begin
            {step_hi, step_lo} = {sum, acc_lo[31:1]};
        end
    end

    always_comb begin
        prod   = {acc_hi, acc_lo};
        prod_c = neg_q ? -prod : prod;
        quo    = neg_q ? -acc_lo : acc_lo;
        rem    = neg_rem_q ? -acc_hi : acc_hi;
        if (div_q) begin
            if (y_zero_q) begin
                res_hi = x_q;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = rem;
                res_lo = quo;
            end
        end else begin
            res_hi = prod_c[63:32];
            res_lo = prod_c[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= 6'd0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            y_zero_q  <= 1'b0;
            x_q       <= 32'd0;
            acc_hi    <= 32'd0;
            acc_lo    <= 32'd0;
            mag       <= 32'd0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            cnt       <= 6'd0;
            div_q     <= op[1];
            neg_q     <= is_signed && (x[31] ^ y[31]);
            neg_rem_q <= is_signed && x[31];
            y_zero_q  <= (y == 32'd0);
            x_q       <= x;
            acc_hi    <= 32'd0;
            acc_lo    <= op[1] ? x_mag : y_mag;
            mag       <= op[1] ? y_mag : x_mag;
            div_zero  <= 1'b0;
            if (fast_div0) begin
                hi       <= x;
                lo       <= 32'hFFFF_FFFF;
                div_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            if (cnt == 6'd32) begin
                hi       <= res_hi;
                lo       <= res_lo;
                div_zero <= div_q && y_zero_q;
            end else begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                cnt    <= cnt + 6'd1;
            end
        end
    end

endmodule
